// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in/serial-out transmitter with a frame qualifier.
// Ports:
//   clk, reset (async, active-high)
//   in_data[WIDTH-1:0], in_valid -> in_ready : word handshake
//   sout, sframe, busy, done                  : registered serial outputs
module piso_shift_tx #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1,
    parameter int DIV       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sframe,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    logic             bit_end;

    assign in_ready = ~reset & (state == IDLE);
    assign bit_end  = (div_cnt == DIV_LAST);

    // sout is loaded with the first bit on the accept edge; shreg keeps
    // only the bits still to be sent, aligned so the next one sits at
    // the end that is shifted out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            sout    <= 1'b0;
            sframe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state   <= SHIFT;
                        sframe  <= 1'b1;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        if (LSB_FIRST) begin
                            sout  <= in_data[0];
                            shreg <= in_data >> 1;
                        end else begin
                            sout  <= in_data[WIDTH-1];
                            shreg <= in_data << 1;
                        end
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            shreg   <= '0;
                            sout    <= 1'b0;
                            sframe  <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (LSB_FIRST) begin
                                sout  <= shreg[0];
                                shreg <= shreg >> 1;
                            end else begin
                                sout  <= shreg[WIDTH-1];
                                shreg <= shreg << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: directed bench for piso_shift_tx in three configurations
// (LSB first DIV=1, MSB first DIV=1, LSB first DIV=3) with a bit scoreboard.
module tb_piso_shift_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] d [3];
    logic [2:0] v;
    wire  [2:0] rdy, so, sf, bz, dn;

    int vectors = 0;
    int miscompares = 0;
    logic q [$];

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(4), .LSB_FIRST(1'b1), .DIV(1)) u0 (
        .clk(clk), .reset(reset), .in_data(d[0]), .in_valid(v[0]),
        .in_ready(rdy[0]), .sout(so[0]), .sframe(sf[0]), .busy(bz[0]),
        .done(dn[0]));

    piso_shift_tx #(.WIDTH(4), .LSB_FIRST(1'b0), .DIV(1)) u1 (
        .clk(clk), .reset(reset), .in_data(d[1]), .in_valid(v[1]),
        .in_ready(rdy[1]), .sout(so[1]), .sframe(sf[1]), .busy(bz[1]),
        .done(dn[1]));

    piso_shift_tx #(.WIDTH(4), .LSB_FIRST(1'b1), .DIV(3)) u2 (
        .clk(clk), .reset(reset), .in_data(d[2]), .in_valid(v[2]),
        .in_ready(rdy[2]), .sout(so[2]), .sframe(sf[2]), .busy(bz[2]),
        .done(dn[2]));

    function automatic int div_of(int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic bit lsb_of(int i);
        return (i == 1) ? 1'b0 : 1'b1;
    endfunction

    task automatic chk(string tag, logic obs, logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(int i, logic exp_rdy, logic exp_done);
        chk("idle_sout", so[i], 1'b0);
        chk("idle_sframe", sf[i], 1'b0);
        chk("idle_busy", bz[i], 1'b0);
        chk("idle_ready", rdy[i], exp_rdy);
        chk("idle_done", dn[i], exp_done);
    endtask

    // Drive a word and push its expected serial bits to the scoreboard.
    task automatic load(int i, logic [3:0] data);
        logic b;
        d[i] = data;
        v[i] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b = lsb_of(i) ? data[k] : data[3-k];
            repeat (div_of(i)) q.push_back(b);
        end
    endtask

    // mode 0: drop valid after accept
    // mode 1: keep valid, swap in_data to nd right after accept
    // mode 2: drop valid, then spam valid with nd mid-frame
    // Returns at the negedge of the done cycle.
    task automatic frame(int i, int mode, logic [3:0] nd);
        int n;
        logic e;
        n = 4 * div_of(i);
        @(posedge clk);
        #1;
        if (mode == 1) d[i] = nd;
        else v[i] = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                chk("scoreboard_empty", 1'b1, 1'b0);
                e = 1'b0;
            end else begin
                e = q.pop_front();
            end
            chk("sout", so[i], e);
            chk("sframe", sf[i], 1'b1);
            chk("busy", bz[i], 1'b1);
            chk("ready_in_frame", rdy[i], 1'b0);
            chk("done_in_frame", dn[i], 1'b0);
            if (mode == 2 && k == 1) begin
                d[i] = nd;
                v[i] = 1'b1;
            end
            if (mode == 2 && k == n - 1) v[i] = 1'b0;
        end
        @(negedge clk);
        chk_idle(i, 1'b1, 1'b1);
    endtask

    initial begin
        v = '0;
        for (int i = 0; i < 3; i++) d[i] = '0;

        #1;
        for (int i = 0; i < 3; i++) chk_idle(i, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle(i, 1'b1, 1'b0);

        // 1: LSB first, DIV=1
        load(0, 4'b0011);
        frame(0, 0, 4'b0000);
        @(negedge clk);
        chk_idle(0, 1'b1, 1'b0);

        // 2: MSB first
        load(1, 4'b1010);
        frame(1, 0, 4'b0000);
        @(negedge clk);
        chk_idle(1, 1'b1, 1'b0);

        // 3: DIV=3
        load(2, 4'b0110);
        frame(2, 0, 4'b0000);
        @(negedge clk);
        chk_idle(2, 1'b1, 1'b0);

        // 4: back-to-back, in_data changed after accept
        load(0, 4'b0001);
        frame(0, 1, 4'b1000);
        load(0, 4'b1000);
        frame(0, 0, 4'b0000);
        @(negedge clk);
        chk_idle(0, 1'b1, 1'b0);

        // 5: valid during frame ignored
        load(0, 4'b1111);
        frame(0, 2, 4'b0000);
        repeat (3) begin
            @(negedge clk);
            chk_idle(0, 1'b1, 1'b0);
        end

        // 6: async reset mid-frame
        load(0, 4'b1111);
        @(posedge clk);
        #1 v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk_idle(0, 1'b0, 1'b0);
        q.delete();
        @(posedge clk);
        #1;
        chk_idle(0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_idle(0, 1'b1, 1'b0);
        end
        load(0, 4'b0101);
        frame(0, 0, 4'b0000);
        @(negedge clk);
        chk_idle(0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
